// File: rtl/kmap_sweep_checker_pkg.sv
// kmap_pkg: golden kmap truth tables, widths and the sweep FSM state type.
package kmap_pkg;
  localparam int IDX_W = 4;
  localparam int ERR_W = 5;
  localparam int CNT_W = 4;
  localparam logic [15:0] KMAP_F0_EXP  = 16'h6996;
  localparam logic [15:0] KMAP_F1_EXP  = 16'hEDE0;
  localparam logic [15:0] KMAP_F2_EXP  = 16'hD1CC;
  localparam logic [15:0] KMAP_F0_CARE = 16'hFFFF;
  localparam logic [15:0] KMAP_F1_CARE = 16'hFFFF;
  localparam logic [15:0] KMAP_F2_CARE = 16'hDDDD;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
endpackage

// File: rtl/kmap_golden_cmp.sv
// kmap_golden_cmp: flags a code whose kmap outputs differ from the golden table on a cared bit.
//   idx             in  4  code applied to the kmap
//   f_0, f_1, f_2   in  1  observed kmap outputs
//   fail            out 1  any cared output mismatches
module kmap_golden_cmp
  import kmap_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             f_0,
  input  logic             f_1,
  input  logic             f_2,
  output logic             fail
);
  assign fail = (KMAP_F0_CARE[idx] & (f_0 != KMAP_F0_EXP[idx])) |
                (KMAP_F1_CARE[idx] & (f_1 != KMAP_F1_EXP[idx])) |
                (KMAP_F2_CARE[idx] & (f_2 != KMAP_F2_EXP[idx]));
endmodule

// File: rtl/kmap_sweep_checker.sv
// kmap_sweep_checker: sweeps ABCD over 0..15, samples F after a settle delay and scores it against the golden table.
//   clk, rst                 clock, synchronous active-high reset
//   start                    launch a sweep (honoured only while idle)
//   A, B, C, D               stimulus, {A,B,C,D} = current code
//   F_0, F_1, F_2            kmap outputs under test
//   busy, done               sweep in progress / one-cycle end pulse
//   pass                     last sweep had no mismatches
//   err_cnt                  mismatching codes this sweep
//   first_fail_idx/_vld      first mismatching code and its valid flag
module kmap_sweep_checker
  import kmap_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter bit STOP_ON_FAIL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  input  logic             F_0,
  input  logic             F_1,
  input  logic             F_2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic             first_fail_vld
);
  state_t state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic fail;
  kmap_golden_cmp u_cmp (.idx(idx), .f_0(F_0), .f_1(F_1), .f_2(F_2), .fail(fail));
  // idx is only updated on entry to DRIVE, so it doubles as the registered stimulus.
  assign {A, B, C, D} = idx;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? DRIVE : IDLE;
      DRIVE:   state_nxt = (cnt == CNT_W'(SETTLE_CYCLES - 1)) ? SAMPLE : DRIVE;
      SAMPLE:  state_nxt = (idx == '1 || (STOP_ON_FAIL && fail)) ? DONE : DRIVE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      idx            <= '0;
      cnt            <= '0;
      err_cnt        <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
      pass           <= 1'b0;
    end else if (state == IDLE && start) begin
      idx            <= '0;
      cnt            <= '0;
      err_cnt        <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
      pass           <= 1'b0;
    end else if (state == DRIVE) begin
      cnt <= cnt + CNT_W'(1);
    end else if (state == SAMPLE) begin
      cnt <= '0;
      if (fail) err_cnt <= err_cnt + ERR_W'(1);
      if (fail && !first_fail_vld) begin
        first_fail_idx <= idx;
        first_fail_vld <= 1'b1;
      end
      if (state_nxt == DRIVE) idx <= idx + IDX_W'(1);
      // pass must account for the code being sampled right now
      if (state_nxt == DONE) pass <= !fail && err_cnt == '0;
    end
endmodule

// File: tb/tb_kmap_sweep_checker.sv
// tb_kmap_sweep_checker: scoreboard bench driving three checker configurations against a behavioural kmap.
module tb_kmap_sweep_checker;
  localparam logic [15:0] F1_TAB = 16'hEDE0;
  localparam logic [15:0] F2_TAB = 16'hD1CC;
  typedef struct {
    int         lat;
    logic [4:0] err;
    logic       ps;
    logic       vld;
    logic [3:0] ffi;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] st = '0;
  logic [2:0] bz, dn, ps, fv;
  logic [4:0] ec [3];
  logic [3:0] fi [3];
  logic [3:0] ab [3];
  logic [2:0] f [3];
  int mode [3] = '{0, 0, 0};
  int checks = 0;
  int failures = 0;
  exp_t sbq [$];
  always #5 clk = ~clk;
  // mode 1: F_2 inverted on don't-care codes, 2: F_0 stuck-at-0, 3: F_1 stuck-at-1
  function automatic logic [2:0] kmap_model(input logic [3:0] i, input int m);
    logic f0, f1, f2;
    f0 = ^i;
    f1 = F1_TAB[i];
    f2 = F2_TAB[i];
    if (m == 1 && i[1:0] == 2'b01) f2 = ~f2;
    if (m == 2) f0 = 1'b0;
    if (m == 3) f1 = 1'b1;
    return {f2, f1, f0};
  endfunction
  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign f[g] = kmap_model(ab[g], mode[g]);
    kmap_sweep_checker #(.SETTLE_CYCLES(g == 2 ? 3 : 1), .STOP_ON_FAIL(g == 1)) u_dut (
      .clk(clk), .rst(rst), .start(st[g]),
      .A(ab[g][3]), .B(ab[g][2]), .C(ab[g][1]), .D(ab[g][0]),
      .F_0(f[g][0]), .F_1(f[g][1]), .F_2(f[g][2]),
      .busy(bz[g]), .done(dn[g]), .pass(ps[g]), .err_cnt(ec[g]),
      .first_fail_idx(fi[g]), .first_fail_vld(fv[g])
    );
  end
  task automatic launch(input int g, input exp_t e);
    sbq.push_back(e);
    @(negedge clk) st[g] = 1'b1;
    @(negedge clk) st[g] = 1'b0;
  endtask
  task automatic wait_done(input int g, output int n);
    n = 1;
    while (!dn[g] && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic test_reset;
    for (int g = 0; g < 3; g++) begin
      if ({bz[g], dn[g], ps[g], fv[g]} !== 4'b0 || ec[g] !== 5'd0 || fi[g] !== 4'd0 || ab[g] !== 4'd0) begin
        $display("FAIL reset dut%0d got busy=%b done=%b pass=%b vld=%b err=%0d ffi=%0d abcd=%0d exp all zero",
                 g, bz[g], dn[g], ps[g], fv[g], ec[g], fi[g], ab[g]);
        failures++;
      end
      checks++;
    end
  endtask
  task automatic test_clean;
    int n;
    exp_t e;
    mode[0] = 0;
    launch(0, '{33, 5'd0, 1'b1, 1'b0, 4'd0});
    if (bz[0] !== 1'b1 || ab[0] !== 4'd0) begin
      $display("FAIL clean_busy got busy=%b abcd=%0d exp busy=1 abcd=0", bz[0], ab[0]); failures++;
    end
    checks++;
    wait_done(0, n);
    e = sbq.pop_front();
    if (n != e.lat) begin $display("FAIL clean_lat got=%0d exp=%0d", n, e.lat); failures++; end
    checks++;
    if (ec[0] !== e.err || ps[0] !== e.ps || fv[0] !== e.vld) begin
      $display("FAIL clean_result got err=%0d pass=%b vld=%b exp err=%0d pass=%b vld=%b", ec[0], ps[0], fv[0], e.err, e.ps, e.vld);
      failures++;
    end
    checks++;
    @(negedge clk);
    if (dn[0] !== 1'b0 || bz[0] !== 1'b0 || ps[0] !== 1'b1) begin
      $display("FAIL clean_after got done=%b busy=%b pass=%b exp done=0 busy=0 pass=1", dn[0], bz[0], ps[0]); failures++;
    end
    checks++;
  endtask
  task automatic test_dont_care;
    int n;
    exp_t e;
    mode[0] = 1;
    launch(0, '{33, 5'd0, 1'b1, 1'b0, 4'd0});
    wait_done(0, n);
    e = sbq.pop_front();
    if (n != e.lat || ec[0] !== e.err || ps[0] !== e.ps || fv[0] !== e.vld) begin
      $display("FAIL dont_care got lat=%0d err=%0d pass=%b vld=%b exp lat=%0d err=%0d pass=%b vld=%b",
               n, ec[0], ps[0], fv[0], e.lat, e.err, e.ps, e.vld);
      failures++;
    end
    checks++;
    @(negedge clk);
  endtask
  task automatic test_stuck_f0;
    int n;
    exp_t e;
    mode[0] = 2;
    launch(0, '{33, 5'd8, 1'b0, 1'b1, 4'd1});
    wait_done(0, n);
    e = sbq.pop_front();
    if (n != e.lat) begin $display("FAIL stuck_f0_lat got=%0d exp=%0d", n, e.lat); failures++; end
    checks++;
    if (ec[0] !== e.err) begin $display("FAIL stuck_f0_err got=%0d exp=%0d", ec[0], e.err); failures++; end
    checks++;
    if (fv[0] !== e.vld || fi[0] !== e.ffi || ps[0] !== e.ps) begin
      $display("FAIL stuck_f0_first got vld=%b ffi=%0d pass=%b exp vld=%b ffi=%0d pass=%b", fv[0], fi[0], ps[0], e.vld, e.ffi, e.ps);
      failures++;
    end
    checks++;
    @(negedge clk);
    mode[0] = 0;
  endtask
  task automatic test_stop_on_fail;
    int n;
    exp_t e;
    mode[1] = 3;
    launch(1, '{3, 5'd1, 1'b0, 1'b1, 4'd0});
    wait_done(1, n);
    e = sbq.pop_front();
    if (n != e.lat) begin $display("FAIL stop_lat got=%0d exp=%0d", n, e.lat); failures++; end
    checks++;
    if (ec[1] !== e.err || fv[1] !== e.vld || fi[1] !== e.ffi || ps[1] !== e.ps) begin
      $display("FAIL stop_result got err=%0d vld=%b ffi=%0d pass=%b exp err=%0d vld=%b ffi=%0d pass=%b",
               ec[1], fv[1], fi[1], ps[1], e.err, e.vld, e.ffi, e.ps);
      failures++;
    end
    checks++;
    @(negedge clk);
    if (bz[1] !== 1'b0) begin $display("FAIL stop_idle got busy=%b exp 0", bz[1]); failures++; end
    checks++;
    mode[1] = 0;
  endtask
  task automatic test_rst_mid;
    int n, k;
    exp_t e;
    mode[0] = 2;
    @(negedge clk) st[0] = 1'b1;
    @(negedge clk) st[0] = 1'b0;
    k = 0;
    while (ab[0] !== 4'd7 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin $display("FAIL rst_mid_reach got abcd=%0d exp 7", ab[0]); failures++; end
    checks++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mode[0] = 0;
    if ({bz[0], dn[0], ps[0], fv[0]} !== 4'b0 || ec[0] !== 5'd0 || fi[0] !== 4'd0 || ab[0] !== 4'd0) begin
      $display("FAIL rst_mid got busy=%b done=%b pass=%b vld=%b err=%0d ffi=%0d abcd=%0d exp all zero",
               bz[0], dn[0], ps[0], fv[0], ec[0], fi[0], ab[0]);
      failures++;
    end
    checks++;
    repeat (3) @(negedge clk);
    if (dn[0] !== 1'b0 || bz[0] !== 1'b0) begin $display("FAIL rst_mid_idle got done=%b busy=%b exp 0 0", dn[0], bz[0]); failures++; end
    checks++;
    launch(0, '{33, 5'd0, 1'b1, 1'b0, 4'd0});
    wait_done(0, n);
    e = sbq.pop_front();
    if (n != e.lat || ps[0] !== e.ps || ec[0] !== e.err) begin
      $display("FAIL rst_rerun got lat=%0d pass=%b err=%0d exp lat=%0d pass=%b err=%0d", n, ps[0], ec[0], e.lat, e.ps, e.err);
      failures++;
    end
    checks++;
    @(negedge clk);
  endtask
  task automatic test_back_to_back;
    int n;
    exp_t e;
    sbq.push_back('{65, 5'd0, 1'b1, 1'b0, 4'd0});
    sbq.push_back('{65, 5'd0, 1'b1, 1'b0, 4'd0});
    @(negedge clk) st[2] = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      wait_done(2, n);
      e = sbq.pop_front();
      if (n != e.lat || ps[2] !== e.ps || ec[2] !== e.err) begin
        $display("FAIL b2b_sweep%0d got lat=%0d pass=%b err=%0d exp lat=%0d pass=%b err=%0d", s, n, ps[2], ec[2], e.lat, e.ps, e.err);
        failures++;
      end
      checks++;
      @(negedge clk);
      if (dn[2] !== 1'b0 || bz[2] !== 1'b0) begin
        $display("FAIL b2b_gap%0d got done=%b busy=%b exp 0 0", s, dn[2], bz[2]); failures++;
      end
      checks++;
      if (s == 1) st[2] = 1'b0;
      @(negedge clk);
    end
    if (bz[2] !== 1'b0) begin $display("FAIL b2b_stop got busy=%b exp 0", bz[2]); failures++; end
    checks++;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_clean;
    test_dont_care;
    test_stuck_f0;
    test_stop_on_fail;
    test_rst_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
